// File: rtl/regfile_sb.sv
// regfile_sb: multi-ported register file with a per-register scoreboard.
// Register 0 is hardwired to zero. Each register carries a busy bit that
// marks a pending writeback: a reservation sets it and a write clears it.
// A reservation is refused (rsv_ok=0) while the target is still busy,
// unless a write to that target lands in the same cycle.
// Optional macro REGFILE_SB_BYPASS_EN forwards same-cycle write data to
// the read ports.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  localparam int AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*XLEN-1:0]   wr_data,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  output logic                     rsv_ok
);

  logic [XLEN-1:0]     r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;

  logic [AW-1:0]       w_rdAddr [NUM_RD];
  logic [AW-1:0]       w_wrAddr [NUM_WR];
  logic [XLEN-1:0]     w_wrData [NUM_WR];

  logic [NUM_REGS-1:0] w_wrHit;
  logic [XLEN-1:0]     w_wrHitData [NUM_REGS];

  logic [NUM_REGS-1:0] w_rsvTarget;
  logic                w_rsvBusy;
  logic                w_rsvWrHit;

  // Unpack the flat address/data buses into per-port arrays.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      w_rdAddr[i] = rd_addr[i*AW +: AW];
    end
    for (int j = 0; j < NUM_WR; j++) begin
      w_wrAddr[j] = wr_addr[j*AW +: AW];
      w_wrData[j] = wr_data[j*XLEN +: XLEN];
    end
  end

  // Per-register write decode; scanning ports upward lets the highest index win.
  // Register 0 and out-of-range addresses never match, so those writes drop out.
  always_comb begin
    w_wrHit = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      w_wrHitData[k] = '0;
    end
    for (int k = 1; k < NUM_REGS; k++) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (w_wrAddr[j] == AW'(k))) begin
          w_wrHit[k]     = 1'b1;
          w_wrHitData[k] = w_wrData[j];
        end
      end
    end
  end

  // Reservation lookup. Register 0 and out-of-range addresses look idle, which
  // makes them always accepted without ever touching a busy bit.
  always_comb begin
    w_rsvTarget = '0;
    w_rsvBusy   = 1'b0;
    w_rsvWrHit  = 1'b0;
    for (int k = 1; k < NUM_REGS; k++) begin
      if (rsv_addr == AW'(k)) begin
        w_rsvTarget[k] = 1'b1;
        w_rsvBusy      = r_busy[k];
        w_rsvWrHit     = w_wrHit[k];
      end
    end
    rsv_ok = !rst && rsv_en && (!w_rsvBusy || w_rsvWrHit);
  end

  // Register storage: clear on reset, otherwise take the winning write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      for (int k = 1; k < NUM_REGS; k++) begin
        if (w_wrHit[k]) begin
          r_regs[k] <= w_wrHitData[k];
        end
      end
    end
  end

  // Busy bits: writes clear, an accepted reservation sets and overrides the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_wrHit) | (rsv_ok ? w_rsvTarget : '0);
    end
  end

  // Combinational read ports; disabled, zero and out-of-range reads return 0/idle.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_en[i]) begin
        for (int k = 1; k < NUM_REGS; k++) begin
          if (w_rdAddr[i] == AW'(k)) begin
`ifdef REGFILE_SB_BYPASS_EN
            if (w_wrHit[k]) begin
              rd_data[i*XLEN +: XLEN] = w_wrHitData[k];
              rd_busy[i]              = 1'b0;
            end else begin
              rd_data[i*XLEN +: XLEN] = r_regs[k];
              rd_busy[i]              = r_busy[k];
            end
`else
            rd_data[i*XLEN +: XLEN] = r_regs[k];
            rd_busy[i]              = r_busy[k];
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector table followed by randomized traffic
// compared against a behavioural model of the register file.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 24;
  localparam int AW    = 5;
`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      rd_en;
  logic [2*AW-1:0] rd_addr;
  logic [63:0]     rd_data;
  logic [1:0]      rd_busy;
  logic [1:0]      wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [63:0]     wr_data;
  logic            rsv_en;
  logic [AW-1:0]   rsv_addr;
  logic            rsv_ok;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NUM_REGS(NREGS), .NUM_RD(2), .NUM_WR(2)) dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  rdEn;
    logic [4:0]  ra0, ra1;
    logic [1:0]  wrEn;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        rsvEn;
    logic [4:0]  rsvAddr;
    logic [31:0] expD0, expD1;
    logic [1:0]  expBusy;
    logic        expOk;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: plain arrays indexed by the full 5-bit address space.
  logic [31:0] mMem  [32];
  bit          mBusy [32];

  function automatic vec_t mkVec(
    input logic r, input logic [1:0] rdE, input logic [4:0] a0, input logic [4:0] a1,
    input logic [1:0] wrE, input logic [4:0] w0, input logic [31:0] d0,
    input logic [4:0] w1, input logic [31:0] d1, input logic rE, input logic [4:0] rA,
    input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eB, input logic eOk);
    vec_t v;
    v.rst = r; v.rdEn = rdE; v.ra0 = a0; v.ra1 = a1;
    v.wrEn = wrE; v.wa0 = w0; v.wd0 = d0; v.wa1 = w1; v.wd1 = d1;
    v.rsvEn = rE; v.rsvAddr = rA;
    v.expD0 = e0; v.expD1 = e1; v.expBusy = eB; v.expOk = eOk;
    return v;
  endfunction

  function automatic bool_wr_hits(input logic [4:0] a);
    return (wr_en[0] && wr_addr[4:0] == a) || (wr_en[1] && wr_addr[9:5] == a);
  endfunction

  function automatic void modelRead(input logic en, input logic [4:0] a,
                                    output logic [31:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (en && a != 0 && int'(a) < NREGS) begin
      d = mMem[a];
      b = mBusy[a];
      if (BYP) begin
        if (wr_en[0] && wr_addr[4:0] == a) begin d = wr_data[31:0];  b = 1'b0; end
        if (wr_en[1] && wr_addr[9:5] == a) begin d = wr_data[63:32]; b = 1'b0; end
      end
    end
  endfunction

  function automatic logic modelRsvOk();
    logic [4:0] a;
    a = rsv_addr;
    if (rst || !rsv_en) return 1'b0;
    if (a == 0 || int'(a) >= NREGS) return 1'b1;
    return !mBusy[a] || bool_wr_hits(a);
  endfunction

  // Apply the current inputs to the model as the rising edge would.
  function automatic void modelStep();
    logic ok;
    logic [4:0] a;
    ok = modelRsvOk();
    if (rst) begin
      for (int k = 0; k < 32; k++) begin mMem[k] = '0; mBusy[k] = 1'b0; end
    end else begin
      for (int j = 0; j < 2; j++) begin
        a = (j == 0) ? wr_addr[4:0] : wr_addr[9:5];
        if (wr_en[j] && a != 0 && int'(a) < NREGS) begin
          mMem[a]  = (j == 0) ? wr_data[31:0] : wr_data[63:32];
          mBusy[a] = 1'b0;
        end
      end
      a = rsv_addr;
      if (ok && a != 0 && int'(a) < NREGS) mBusy[a] = 1'b1;
    end
  endfunction

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst      = v.rst;
    rd_en    = v.rdEn;
    rd_addr  = {v.ra1, v.ra0};
    wr_en    = v.wrEn;
    wr_addr  = {v.wa1, v.wa0};
    wr_data  = {v.wd1, v.wd0};
    rsv_en   = v.rsvEn;
    rsv_addr = v.rsvAddr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [1:0] eB, input logic eOk);
    check1({tag, "_data0"}, rd_data[31:0], e0);
    check1({tag, "_data1"}, rd_data[63:32], e1);
    check1({tag, "_busy"}, {30'd0, rd_busy}, {30'd0, eB});
    check1({tag, "_rsvok"}, {31'd0, rsv_ok}, {31'd0, eOk});
  endtask

  initial begin
    vec_t v;
    logic [31:0] m0, m1;
    logic b0, b1;

    for (int k = 0; k < 32; k++) begin mMem[k] = '0; mBusy[k] = 1'b0; end

    // Directed sequence covering reset, writes, x0, port priority, scoreboard, bypass.
    tbl.push_back(mkVec(1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1, 3, 0, 0, 2'b00, 0));
    tbl.push_back(mkVec(0, 2'b11, 0, 1, 2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    tbl.push_back(mkVec(0, 2'b11, 5, 5, 2'b01, 0, 32'h1234, 0, 0, 1, 0,
                        32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1));
    tbl.push_back(mkVec(0, 2'b11, 0, 0, 2'b11, 7, 32'h11, 7, 32'h22, 0, 0, 0, 0, 2'b00, 0));
    tbl.push_back(mkVec(0, 2'b11, 7, 0, 2'b00, 0, 0, 0, 0, 1, 3, 32'h22, 0, 2'b00, 1));
    tbl.push_back(mkVec(0, 2'b11, 3, 7, 2'b00, 0, 0, 0, 0, 1, 3, 0, 32'h22, 2'b01, 0));
    tbl.push_back(mkVec(0, 2'b11, 3, 7, 2'b00, 0, 0, 0, 0, 1, 3, 0, 32'h22, 2'b01, 0));
    tbl.push_back(mkVec(0, 2'b00, 0, 0, 2'b10, 0, 0, 3, 32'h55, 0, 0, 0, 0, 2'b00, 0));
    tbl.push_back(mkVec(0, 2'b01, 3, 0, 2'b00, 0, 0, 0, 0, 1, 3, 32'h55, 0, 2'b00, 1));
    tbl.push_back(mkVec(0, 2'b00, 0, 0, 2'b01, 3, 32'h66, 0, 0, 1, 3, 0, 0, 2'b00, 1));
    tbl.push_back(mkVec(0, 2'b01, 3, 0, 2'b00, 0, 0, 0, 0, 1, 3, 32'h66, 0, 2'b01, 0));
    tbl.push_back(mkVec(0, 2'b10, 0, 9, 2'b10, 0, 0, 9, 32'hA5A5A5A5, 0, 0,
                        0, BYP ? 32'hA5A5A5A5 : 32'h0, 2'b00, 0));
    tbl.push_back(mkVec(0, 2'b10, 0, 9, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'hA5A5A5A5, 2'b00, 0));
    tbl.push_back(mkVec(1, 2'b01, 9, 0, 2'b01, 4, 32'h77, 0, 0, 1, 6, 32'hA5A5A5A5, 0, 2'b00, 0));
    tbl.push_back(mkVec(0, 2'b11, 4, 3, 2'b00, 0, 0, 0, 0, 1, 6, 0, 0, 2'b00, 1));
    tbl.push_back(mkVec(0, 2'b11, 25, 31, 2'b01, 26, 32'hFFFF, 0, 0, 1, 30, 0, 0, 2'b00, 1));
    tbl.push_back(mkVec(0, 2'b11, 26, 30, 2'b00, 0, 0, 0, 0, 1, 30, 0, 0, 2'b00, 1));

    foreach (tbl[i]) begin
      v = tbl[i];
      applyStimulus(v);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), v.expD0, v.expD1, v.expBusy, v.expOk);
      modelStep();
      @(posedge clk);
      #1;
    end

    // Randomized traffic on a small address window so collisions are frequent.
    for (int n = 0; n < 400; n++) begin
      v.rst     = ($urandom_range(0, 49) == 0);
      v.rdEn    = 2'($urandom_range(0, 3));
      v.ra0     = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      v.ra1     = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      v.wrEn    = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      v.wa0     = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      v.wa1     = 5'($urandom_range(0, 7));
      v.wd0     = $urandom;
      v.wd1     = $urandom;
      v.rsvEn   = ($urandom_range(0, 1) == 1);
      v.rsvAddr = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      applyStimulus(v);
      @(negedge clk);
      modelRead(rd_en[0], rd_addr[4:0], m0, b0);
      modelRead(rd_en[1], rd_addr[9:5], m1, b1);
      checkOutput($sformatf("rnd%0d", n), m0, m1, {b1, b0}, modelRsvOk());
      modelStep();
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
